// File: rtl/serial_word_receiver_pkg.sv
// -----------------------------------------------------------------------------
// serial_word_receiver_pkg
// Shared definitions for the serial word receiver slice:
//   - DEFAULT_WIDTH : default number of data bits per frame
//   - state_e       : receive FSM state encoding
//   - odd_ones()    : reduction-XOR helper used for even-parity checking
// Optional feature macro used by this slice: SERIAL_PARITY_EN
// -----------------------------------------------------------------------------
package serial_word_receiver_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Returns 1 when the vector holds an odd number of ones. Narrower words are
  // zero-extended by the caller, which does not change the result.
  function automatic logic odd_ones(input logic [15:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_word_receiver_if
// Groups the serial input, the bit strobe and the consumer handshake.
//   en         : bit strobe (one bit sampled per cycle with en=1)
//   din        : serial stream, idle level 1
//   ready      : consumer accepts the presented word this cycle
//   data       : received word (WIDTH bits, LSB received first)
//   valid      : data holds an unconsumed word
//   frame_err  : one-cycle pulse, stop bit sampled as 0
//   overrun    : sticky, a word was overwritten before acceptance
//   parity_err : one-cycle pulse, parity mismatch (only with SERIAL_PARITY_EN)
// Modports: master = stream source / consumer side, slave = receiver.
// -----------------------------------------------------------------------------
interface serial_word_receiver_if
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             en;
  logic             din;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             frame_err;
  logic             overrun;
`ifdef SERIAL_PARITY_EN
  logic             parity_err;

  modport master (output en, din, ready,
                  input  data, valid, frame_err, overrun, parity_err);
  modport slave  (input  en, din, ready,
                  output data, valid, frame_err, overrun, parity_err);
`else
  modport master (output en, din, ready,
                  input  data, valid, frame_err, overrun);
  modport slave  (input  en, din, ready,
                  output data, valid, frame_err, overrun);
`endif

endinterface

// File: rtl/serial_word_receiver_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for a single bit. Both flops reset to 1 so an idle
// serial line (level 1) is reported immediately after reset.
//   clk : rising-edge clock
//   r   : asynchronous active-low reset
//   d   : asynchronous input bit
//   q   : synchronized bit, two clk cycles behind d
// -----------------------------------------------------------------------------
module bit_sync (
  input  logic clk,
  input  logic r,
  input  logic d,
  output logic q
);

  logic [1:0] sync_r;

  // Two-stage shift toward q; stage 0 may go metastable, stage 1 is used.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], d};
    end
  end

  assign q = sync_r[1];

endmodule

// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
// Frames a registered serial bit stream (start bit 0, WIDTH data bits LSB
// first, optional even-parity bit, stop bit 1), sampling one bit per cycle
// with en=1, and presents each word through a valid/ready handshake.
//   clk : rising-edge clock
//   r   : asynchronous active-low reset
//   bus : serial_word_receiver_if.slave (en, din, ready, data, valid,
//         frame_err, overrun, parity_err)
// Optional feature macro: SERIAL_PARITY_EN adds the parity bit, the PARITY
// state and the parity_err pulse.
// -----------------------------------------------------------------------------
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  r,
  serial_word_receiver_if.slave bus
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             din_s;
  state_e           state_r,     state_n;
  logic [CW-1:0]    cnt_r,       cnt_n;
  logic [WIDTH-1:0] shreg_r,     shreg_n;
  logic [WIDTH-1:0] data_r,      data_n;
  logic             valid_r,     valid_n;
  logic             frame_err_r, frame_err_n;
  logic             overrun_r,   overrun_n;
`ifdef SERIAL_PARITY_EN
  logic             par_bad_r,    par_bad_n;
  logic             parity_err_r, parity_err_n;
`endif

  bit_sync u_din_sync (
    .clk (clk),
    .r   (r),
    .d   (bus.din),
    .q   (din_s)
  );

  // State, datapath and output registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      shreg_r      <= {WIDTH{1'b0}};
      data_r       <= {WIDTH{1'b0}};
      valid_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      shreg_r      <= shreg_n;
      data_r       <= data_n;
      valid_r      <= valid_n;
      frame_err_r  <= frame_err_n;
      overrun_r    <= overrun_n;
`ifdef SERIAL_PARITY_EN
      par_bad_r    <= par_bad_n;
      parity_err_r <= parity_err_n;
`endif
    end
  end

  // Next-state and next-output logic; everything holds unless en=1, except
  // the handshake, which the consumer may complete in any cycle.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    shreg_n     = shreg_r;
    data_n      = data_r;
    valid_n     = valid_r;
    frame_err_n = 1'b0;
    overrun_n   = overrun_r;
`ifdef SERIAL_PARITY_EN
    par_bad_n    = par_bad_r;
    parity_err_n = 1'b0;
`endif

    if (valid_r && bus.ready) begin
      valid_n = 1'b0;
    end else begin
      valid_n = valid_r;
    end

    if (bus.en) begin
      case (state_r)
        ST_IDLE: begin
          // Any 0 in idle is a start bit.
          if (!din_s) begin
            state_n = ST_DATA;
            cnt_n   = {CW{1'b0}};
`ifdef SERIAL_PARITY_EN
            par_bad_n = 1'b0;
`endif
          end else begin
            state_n = ST_IDLE;
          end
        end

        ST_DATA: begin
          // LSB arrives first, so shift in from the top.
          shreg_n = {din_s, shreg_r[WIDTH-1:1]};
          cnt_n   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST) begin
`ifdef SERIAL_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            state_n = ST_DATA;
          end
        end

`ifdef SERIAL_PARITY_EN
        ST_PARITY: begin
          // Even parity: data ones plus the parity bit must be even.
          par_bad_n = odd_ones(16'(shreg_r)) ^ din_s;
          state_n   = ST_STOP;
        end
`endif

        ST_STOP: begin
          state_n = ST_IDLE;
          // A bad stop bit is reported in preference to a parity error.
          if (!din_s) begin
            frame_err_n = 1'b1;
          end
`ifdef SERIAL_PARITY_EN
          else if (par_bad_r) begin
            parity_err_n = 1'b1;
          end
`endif
          else begin
            // Loading while the consumer accepts the old word is not an
            // overrun; loading over an unaccepted word is.
            data_n  = shreg_r;
            valid_n = 1'b1;
            if (valid_r && !bus.ready) begin
              overrun_n = 1'b1;
            end else begin
              overrun_n = overrun_r;
            end
          end
        end

        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  assign bus.data      = data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;
`ifdef SERIAL_PARITY_EN
  assign bus.parity_err = parity_err_r;
`endif

endmodule
